// File: rtl/xfer_ctrl_mc.sv
// Round-robin multi-channel transfer controller: grants one requester at a time onto a shared
// engine, drives the START/ENDD/STOP/ER/ENABLE handshake, a status strobe and delayed per-grant ACKs.
module xfer_ctrl_mc #(
    parameter int NCH     = 4,
    parameter int LEN_W   = 8,
    parameter int ACK_LAT = 5,
    parameter int ER_CYC  = 3,
    parameter int RT_HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         REQ,
    input  logic [NCH*LEN_W-1:0]   LEN,
    input  logic [NCH-1:0]         STOP_REQ,
    input  logic                   ERR_IN,
    input  logic                   RT,
    input  logic                   INTERRUPT,
    output logic                   RDY,
    output logic                   START,
    output logic                   ENDD,
    output logic                   STOP,
    output logic                   ER,
    output logic                   STATUS_VALID,
    output logic [1:0]             STATUS,
    output logic                   ENABLE,
    output logic [NCH-1:0]         ACK,
    output logic [$clog2(NCH)-1:0] GNT_ID
);
    localparam int ID_W = $clog2(NCH);
    localparam logic [2:0] ER_LOAD = 3'(ER_CYC - 1);
    localparam logic [2:0] RT_LOAD = 3'(RT_HOLD - 1);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NCH - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_RUN, ST_ERR, ST_RTH, ST_COOL} state_t;

    state_t           state, state_d;
    logic [LEN_W-1:0] len_q, len_d, cnt, cnt_d, sel_len;
    logic [2:0]       er_cnt, er_cnt_d, rt_cnt, rt_cnt_d;
    logic [ID_W-1:0]  ptr, ptr_d, gnt_d, pick, idx;
    logic             found, grant;
    logic             rdy_d, start_d, endd_d, stop_d, er_d, sv_d, enable_d;
    logic [1:0]       status_d;
    logic [NCH-1:0]   ack_in;
    logic [NCH-1:0]   ack_line [ACK_LAT];

    // Search begins one past the last granted channel so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        idx     = '0;
        sel_len = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = ID_W'((int'(ptr) + i) % NCH);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int c = 0; c < NCH; c++)
            if (pick == ID_W'(c)) sel_len = LEN[c*LEN_W +: LEN_W];
    end

    always_comb begin
        state_d  = state;
        len_d    = len_q;
        cnt_d    = cnt;
        er_cnt_d = er_cnt;
        rt_cnt_d = rt_cnt;
        ptr_d    = ptr;
        gnt_d    = GNT_ID;
        grant    = 1'b0;
        stop_d   = 1'b0;
        sv_d     = 1'b0;
        status_d = STATUS;
        if (RT) begin
            state_d  = ST_RTH;
            rt_cnt_d = RT_LOAD;
            if (state != ST_RTH) begin
                sv_d     = 1'b1;
                status_d = 2'b11;
            end
        end else begin
            case (state)
                ST_IDLE: if (RDY && found) begin
                    grant   = 1'b1;
                    gnt_d   = pick;
                    ptr_d   = pick;
                    len_d   = (sel_len == '0) ? LEN_W'(1) : sel_len;
                    state_d = ST_START;
                end
                ST_START: if (ERR_IN) begin
                    state_d  = ST_ERR;
                    er_cnt_d = ER_LOAD;
                end else if (START) begin
                    state_d = ST_RUN;
                    cnt_d   = len_q;
                end
                // A cycle already showing ENDD or STOP has committed its outcome; only RT overrides it.
                ST_RUN: if (ENDD || STOP) begin
                    state_d  = ST_COOL;
                    sv_d     = 1'b1;
                    status_d = STOP ? 2'b01 : 2'b00;
                end else if (ERR_IN) begin
                    state_d  = ST_ERR;
                    er_cnt_d = ER_LOAD;
                end else if (STOP_REQ[GNT_ID]) begin
                    stop_d = 1'b1;
                end else begin
                    cnt_d = cnt - LEN_W'(1);
                end
                ST_ERR: if (er_cnt == '0) begin
                    state_d  = ST_COOL;
                    sv_d     = 1'b1;
                    status_d = 2'b10;
                end else begin
                    er_cnt_d = er_cnt - 3'd1;
                end
                ST_RTH: if (rt_cnt == '0) state_d = ST_COOL;
                        else rt_cnt_d = rt_cnt - 3'd1;
                default: state_d = ST_IDLE;
            endcase
        end
        rdy_d    = (state_d == ST_IDLE) && !INTERRUPT;
        start_d  = (state_d == ST_START) && !INTERRUPT;
        endd_d   = (state_d == ST_RUN) && (cnt_d == LEN_W'(1)) && !stop_d;
        er_d     = (state_d == ST_ERR);
        enable_d = (state_d != ST_RTH);
        ack_in   = grant ? (NCH'(1) << pick) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            cnt          <= '0;
            er_cnt       <= '0;
            rt_cnt       <= '0;
            ptr          <= PTR_RST;
            GNT_ID       <= '0;
            RDY          <= 1'b0;
            START        <= 1'b0;
            ENDD         <= 1'b0;
            STOP         <= 1'b0;
            ER           <= 1'b0;
            STATUS_VALID <= 1'b0;
            STATUS       <= 2'b00;
            ENABLE       <= 1'b0;
            for (int i = 0; i < ACK_LAT; i++) ack_line[i] <= '0;
        end else begin
            state        <= state_d;
            len_q        <= len_d;
            cnt          <= cnt_d;
            er_cnt       <= er_cnt_d;
            rt_cnt       <= rt_cnt_d;
            ptr          <= ptr_d;
            GNT_ID       <= gnt_d;
            RDY          <= rdy_d;
            START        <= start_d;
            ENDD         <= endd_d;
            STOP         <= stop_d;
            ER           <= er_d;
            STATUS_VALID <= sv_d;
            STATUS       <= status_d;
            ENABLE       <= enable_d;
            ack_line[0]  <= ack_in;
            for (int i = 1; i < ACK_LAT; i++) ack_line[i] <= ack_line[i-1];
        end
    end

    assign ACK = ack_line[ACK_LAT-1];

endmodule

// File: tb/tb_xfer_ctrl_mc.sv
// Directed scenarios push expected strobes and levels into queues; a negedge monitor
// pops and compares whatever the DUT presents, then reports leftovers and the summary.
module tb_xfer_ctrl_mc;
    localparam int NCH   = 4;
    localparam int LEN_W = 8;
    localparam int K_START = 0, K_ENDD = 1, K_STOP = 2, K_SV = 3, K_ACK = 4, K_ER = 5;
    localparam int S_RDY = 0, S_EN = 1, S_GNT = 2, S_STATUS = 3;

    typedef struct { int kind; int cyc; int val; } ev_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       REQ, STOP_REQ, ACK;
    logic [NCH*LEN_W-1:0] LEN;
    logic                 ERR_IN, RT, INTERRUPT;
    logic                 RDY, START, ENDD, STOP, ER, STATUS_VALID, ENABLE;
    logic [1:0]           STATUS, GNT_ID;

    ev_t ev_q[$];
    ev_t lvl_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  done = 1'b0;
    int  g, h;

    xfer_ctrl_mc #(.NCH(NCH), .LEN_W(LEN_W), .ACK_LAT(5), .ER_CYC(3), .RT_HOLD(2)) dut (
        .clk(clk), .rst(rst), .REQ(REQ), .LEN(LEN), .STOP_REQ(STOP_REQ), .ERR_IN(ERR_IN),
        .RT(RT), .INTERRUPT(INTERRUPT), .RDY(RDY), .START(START), .ENDD(ENDD), .STOP(STOP),
        .ER(ER), .STATUS_VALID(STATUS_VALID), .STATUS(STATUS), .ENABLE(ENABLE), .ACK(ACK),
        .GNT_ID(GNT_ID)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_START: return "START";
            K_ENDD:  return "ENDD";
            K_STOP:  return "STOP";
            K_SV:    return "STATUS_VALID";
            K_ACK:   return "ACK";
            default: return "ER";
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_RDY:   return "RDY";
            S_EN:    return "ENABLE";
            S_GNT:   return "GNT_ID";
            default: return "STATUS";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            S_RDY:   return int'(RDY);
            S_EN:    return int'(ENABLE);
            S_GNT:   return int'(GNT_ID);
            default: return int'(STATUS);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic strobe(input int kind, input int val);
        int idx = -1;
        foreach (ev_q[i]) if (idx < 0 && ev_q[i].kind == kind) idx = i;
        if (idx < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected %s at cycle %0d: got value %0d, expected no strobe",
                     kind_name(kind), cyc, val);
        end else begin
            checkOutput({kind_name(kind), " cycle"}, cyc, ev_q[idx].cyc);
            checkOutput({kind_name(kind), " value"}, val, ev_q[idx].val);
            ev_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (START)        strobe(K_START, int'(GNT_ID));
        if (ENDD)         strobe(K_ENDD, 0);
        if (STOP)         strobe(K_STOP, 0);
        if (STATUS_VALID) strobe(K_SV, int'(STATUS));
        if (ACK != '0)    strobe(K_ACK, int'(ACK));
        if (ER)           strobe(K_ER, 0);
        for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].cyc == cyc) begin
                checkOutput(sig_name(lvl_q[i].kind), sig_val(lvl_q[i].kind), lvl_q[i].val);
                lvl_q.delete(i);
            end
        end
        if (done) begin
            foreach (ev_q[i]) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing %s: got none, expected at cycle %0d value %0d",
                         kind_name(ev_q[i].kind), ev_q[i].cyc, ev_q[i].val);
            end
            foreach (lvl_q[i]) begin
                checks++;
                failures++;
                $display("[TB] FAIL unchecked %s: got none, expected %0d at cycle %0d",
                         sig_name(lvl_q[i].kind), lvl_q[i].val, lvl_q[i].cyc);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input int v);
        ev_q.push_back('{kind, c, v});
    endtask

    task automatic expect_lvl(input int s, input int c, input int v);
        lvl_q.push_back('{s, c, v});
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] req, input int ch, input int len);
        REQ = req;
        LEN[ch*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    // Expected cycles: grant g, START g+1, ENDD g+1+N, STATUS g+2+N, ACK g+5.
    initial begin
        rst = 1'b1; REQ = '0; LEN = '0; STOP_REQ = '0; ERR_IN = 1'b0; RT = 1'b0; INTERRUPT = 1'b0;
        tick(3);
        g = cyc;
        expect_lvl(S_RDY, g, 0); expect_lvl(S_EN, g, 0);
        expect_lvl(S_GNT, g, 0); expect_lvl(S_STATUS, g, 0);
        expect_lvl(S_RDY, g + 1, 1); expect_lvl(S_EN, g + 1, 1);
        rst = 1'b0;
        tick(1);

        // Round-robin: all four held with LEN=1, grants every 4 cycles in order 0,1,2,3,0.
        h = cyc;
        for (int c = 0; c < NCH; c++) applyStimulus(4'b1111, c, 1);
        for (int k = 0; k < 5; k++) begin
            expect_ev(K_START, h + 1 + 4*k, k % 4);
            expect_ev(K_ENDD,  h + 2 + 4*k, 0);
            expect_ev(K_SV,    h + 3 + 4*k, 0);
            expect_ev(K_ACK,   h + 5 + 4*k, 1 << (k % 4));
            expect_lvl(S_RDY,  h + 4*k, 1);
            expect_lvl(S_RDY,  h + 3 + 4*k, 0);
        end
        tick(17);
        REQ = '0;
        tick(6);

        // Single request, LEN=3.
        g = cyc;
        applyStimulus(4'b0001, 0, 3);
        expect_ev(K_START, g + 1, 0); expect_ev(K_ENDD, g + 4, 0);
        expect_ev(K_SV, g + 5, 0);    expect_ev(K_ACK, g + 5, 1);
        expect_lvl(S_RDY, g + 5, 0);  expect_lvl(S_RDY, g + 6, 1);
        tick(1); REQ = '0;
        tick(6);

        // Stop in the second RUN cycle of channel 2.
        g = cyc;
        applyStimulus(4'b0100, 2, 5);
        expect_ev(K_START, g + 1, 2); expect_ev(K_STOP, g + 4, 0);
        expect_ev(K_SV, g + 5, 1);    expect_ev(K_ACK, g + 5, 4);
        expect_lvl(S_RDY, g + 5, 0);  expect_lvl(S_RDY, g + 6, 1);
        tick(1); REQ = '0;
        tick(2); STOP_REQ = 4'b0100;
        tick(1); STOP_REQ = '0;
        tick(3);

        // Error held for 10 cycles: ER exactly three cycles, STATUS=10.
        g = cyc;
        applyStimulus(4'b1000, 3, 6);
        expect_ev(K_START, g + 1, 3);
        expect_ev(K_ER, g + 3, 0); expect_ev(K_ER, g + 4, 0); expect_ev(K_ER, g + 5, 0);
        expect_ev(K_SV, g + 6, 2); expect_ev(K_ACK, g + 5, 8);
        expect_lvl(S_RDY, g + 6, 0); expect_lvl(S_RDY, g + 7, 1);
        tick(1); REQ = '0;
        tick(1); ERR_IN = 1'b1;
        tick(10); ERR_IN = 1'b0;

        // Retrain in RUN: ENABLE low two cycles, STATUS=11 at entry, ACK unaffected.
        g = cyc;
        applyStimulus(4'b0001, 0, 8);
        expect_ev(K_START, g + 1, 0); expect_ev(K_SV, g + 4, 3); expect_ev(K_ACK, g + 5, 1);
        expect_lvl(S_EN, g + 3, 1); expect_lvl(S_EN, g + 4, 0);
        expect_lvl(S_EN, g + 5, 0); expect_lvl(S_EN, g + 6, 1);
        expect_lvl(S_RDY, g + 4, 0); expect_lvl(S_RDY, g + 7, 1);
        tick(1); REQ = '0;
        tick(2); RT = 1'b1;
        tick(1); RT = 1'b0;
        tick(4);

        // Reset in RUN drops the pending ACK and restores reset values.
        g = cyc;
        applyStimulus(4'b0100, 2, 10);
        expect_ev(K_START, g + 1, 2);
        expect_lvl(S_GNT, g + 3, 2);  expect_lvl(S_STATUS, g + 3, 3);
        expect_lvl(S_RDY, g + 4, 0);  expect_lvl(S_EN, g + 4, 0);
        expect_lvl(S_GNT, g + 4, 0);  expect_lvl(S_STATUS, g + 4, 0);
        expect_lvl(S_RDY, g + 5, 1);  expect_lvl(S_EN, g + 5, 1);
        tick(1); REQ = '0;
        tick(2); rst = 1'b1;
        tick(1); rst = 1'b0;
        tick(2);

        // LEN=0 behaves as a one-cycle transfer.
        g = cyc;
        applyStimulus(4'b0001, 0, 0);
        expect_ev(K_START, g + 1, 0); expect_ev(K_ENDD, g + 2, 0);
        expect_ev(K_SV, g + 3, 0);    expect_ev(K_ACK, g + 5, 1);
        expect_lvl(S_RDY, g + 3, 0);  expect_lvl(S_RDY, g + 4, 1);
        tick(1); REQ = '0;
        tick(5);

        // INTERRUPT in the grant cycle defers START by one cycle.
        g = cyc;
        applyStimulus(4'b0010, 1, 2);
        INTERRUPT = 1'b1;
        expect_ev(K_START, g + 2, 1); expect_ev(K_ENDD, g + 4, 0);
        expect_ev(K_SV, g + 5, 0);    expect_ev(K_ACK, g + 5, 2);
        expect_lvl(S_RDY, g + 1, 0);  expect_lvl(S_RDY, g + 6, 1);
        tick(1); REQ = '0; INTERRUPT = 1'b0;
        tick(5);

        // INTERRUPT in IDLE masks RDY for exactly the next cycle.
        g = cyc;
        INTERRUPT = 1'b1;
        expect_lvl(S_RDY, g + 1, 0); expect_lvl(S_RDY, g + 2, 1);
        tick(1); INTERRUPT = 1'b0;
        tick(8);
        done = 1'b1;
    end

endmodule

// File: doc/xfer_ctrl_mc.md
# xfer_ctrl_mc

Multi-channel transfer controller that arbitrates up to NCH requesters onto one shared transfer engine. It drives the RDY/START/ENDD/STOP/ER/STATUS_VALID/ENABLE/ACK handshake set under fixed, formally checkable timing rules. It generalises the single-channel handshake block with a parametrised channel count, transfer length, ACK latency and error-burst length, plus round-robin arbitration and a status report.

## Interface
- NCH, 4: number of requesting channels (2..8)
- LEN_W, 8: width of per-channel transfer length
- ACK_LAT, 5: cycles from grant to ACK pulse (1..15)
- ER_CYC, 3: cycles ER is held on an error (1..3)
- RT_HOLD, 2: cycles ENABLE is held low after a retrain (1..7)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- REQ  in  NCH  per-channel request level; held until that channel's ACK
- LEN  in  NCH*LEN_W  per-channel length, channel c at [c*LEN_W +: LEN_W]
- STOP_REQ  in  NCH  per-channel abort request
- ERR_IN  in  1  engine fault
- RT  in  1  retrain request
- INTERRUPT  in  1  interrupt; masks RDY/START
- RDY  out  1  engine idle and able to accept
- START  out  1  one-cycle transfer start pulse
- ENDD  out  1  one-cycle normal completion pulse
- STOP  out  1  one-cycle abort pulse
- ER  out  1  error indication
- STATUS_VALID  out  1  one-cycle status strobe
- STATUS  out  2  00 done, 01 stopped, 10 error, 11 retrain-abort
- ENABLE  out  1  engine enable
- ACK  out  NCH  one-cycle per-channel acknowledge
- GNT_ID  out  $clog2(NCH)  channel currently granted

## Operation
- States: IDLE, START, RUN, ERR, RTH, COOL.
- IDLE: RDY=1 unless masked. If any REQ bit is set and RDY=1, round-robin grant: search starts at (last granted + 1) mod NCH. Latch GNT_ID and LEN, go to START.
- START: START=1 for one cycle, then RUN. The counter is loaded with LEN; LEN=0 is treated as 1.
- RUN: decrement each cycle. On the last cycle ENDD=1, then COOL.
- STOP_REQ[GNT_ID] in RUN: STOP=1 for one cycle, no ENDD, then COOL.
- ERR_IN in START/RUN: enter ERR. ER=1 for exactly ER_CYC cycles, then COOL. ER is never high for more than ER_CYC consecutive cycles.
- RT in any state: abort without ENDD, enter RTH. ENABLE=0 for RT_HOLD cycles starting the next cycle, then COOL. RT arriving during RTH restarts the hold count.
- COOL: one cycle, RDY=0, then IDLE.
- STATUS_VALID=1 with STATUS exactly one cycle after the ENDD/STOP pulse, after the last ER cycle, or at RTH entry (code 11). STATUS holds its value until the next strobe.
- ACK[c] pulses exactly ACK_LAT cycles after the grant cycle of channel c, independent of transfer outcome, RT, INTERRUPT and arbitration. Implement as a per-grant delay line.
- INTERRUPT high in cycle t: RDY=0 and START=0 in cycle t+1. A START due in t+1 is deferred one cycle, state held.
- Event priority in one cycle: rst > RT > ERR_IN > STOP_REQ > completion > INTERRUPT.

## Timing
- All outputs are registered.
- Reset values: RDY=0, START=0, ENDD=0, STOP=0, ER=0, STATUS_VALID=0, STATUS=00, ENABLE=0, ACK=0, GNT_ID=0, round-robin pointer=NCH-1.
- Outputs after reset release: ENABLE=1 and RDY=1 in the first cycle after rst deasserts.
- Grant latency: grant in cycle t, START in t+1, first RUN cycle t+2, ENDD in t+1+N for effective length N.
- Required invariants:
  - ENDD, STOP or ER in cycle t gives RDY=0 in t+1.
  - RT in t gives RDY=0, START=0, ENDD=0 in t+1 and ENABLE=0 for t+1..t+RT_HOLD.
  - ENDD and STATUS_VALID are never high together; START and STATUS_VALID are never high together.
  - INTERRUPT in t gives RDY=0 and START=0 in t+1.
  - REQ granted in t gives ACK in t+ACK_LAT.
- Reset mid-transfer: all state and the ACK delay line are cleared, so pending ACKs are dropped.

## Test plan
- Single request: REQ=0001, LEN[0]=3 → grant t0, START t1, ENDD t4, STATUS_VALID/STATUS=00 t5, RDY t6, ACK[0] t5.
- Round-robin: REQ=1111 held, each channel's LEN=1 → grants in order 0,1,2,3,0; each ACK exactly 5 cycles after its grant.
- Stop and error: STOP_REQ[GNT_ID] in 2nd RUN cycle → STOP pulse, STATUS=01, RDY low next cycle. ERR_IN held 10 cycles → ER high exactly 3 cycles, STATUS=10.
- Retrain mid-RUN: RT in RUN with RT_HOLD=2 → no ENDD, ENABLE low 2 cycles, STATUS_VALID with 11 the next cycle, ACK still at grant+5.
- Interrupt: INTERRUPT in the grant cycle → START delayed one cycle. INTERRUPT in IDLE → RDY low for exactly the next cycle.
- Reset: rst in RUN with an ACK pending → all outputs at reset values next cycle, no ACK; LEN=0 → treated as 1, ENDD at t2.
